// File: rtl/bsg_manycore_pkt_sched.sv
// Arbitrates a tile's single memory port between incoming network packets and local core
// requests, decodes store/config packets, returns credits and bounds core starvation.
module bsg_manycore_pkt_sched #(
  parameter int unsigned x_cord_width_p  = 2,
  parameter int unsigned y_cord_width_p  = 2,
  parameter int unsigned data_width_p    = 32,
  parameter int unsigned addr_width_p    = 10,
  parameter int unsigned max_streak_p    = 4,
  localparam int unsigned mask_width_lp   = data_width_p >> 3,
  localparam int unsigned packet_width_lp = 2 + mask_width_lp + addr_width_p + data_width_p
                                            + y_cord_width_p + x_cord_width_p
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,

  input  logic                       pkt_v_i,
  input  logic [packet_width_lp-1:0] pkt_i,
  output logic                       pkt_yumi_o,

  input  logic                       core_v_i,
  input  logic                       core_w_i,
  input  logic [addr_width_p-1:0]    core_addr_i,
  input  logic [data_width_p-1:0]    core_data_i,
  input  logic [mask_width_lp-1:0]   core_mask_i,
  output logic                       core_yumi_o,

  output logic                       mem_v_o,
  output logic                       mem_w_o,
  output logic [addr_width_p-1:0]    mem_addr_o,
  output logic [data_width_p-1:0]    mem_data_o,
  output logic [mask_width_lp-1:0]   mem_mask_o,
  output logic                       mem_remote_o,
  input  logic                       mem_yumi_i,

  output logic                       freeze_o,
  output logic                       credit_v_o,
  output logic                       error_o
);

  localparam int unsigned StreakW = $clog2(max_streak_p + 1);
  localparam logic [StreakW-1:0] MaxStreak = StreakW'(max_streak_p);

  localparam logic [1:0] OpStore  = 2'd1;
  localparam logic [1:0] OpConfig = 2'd2;

  typedef struct packed {
    logic [1:0]                op;
    logic [mask_width_lp-1:0]  op_ex;
    logic [addr_width_p-1:0]   addr;
    logic [data_width_p-1:0]   data;
    logic [y_cord_width_p-1:0] from_y;
    logic [x_cord_width_p-1:0] from_x;
  } pkt_t;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  pkt_t pkt;
  assign pkt = pkt_i;

  // Source coordinates are not needed: credits go back on the dedicated credit_v_o wire.
  logic unused_src;
  assign unused_src = ^{pkt.from_y, pkt.from_x};

  state_e                    state_q, state_d;
  logic                      mem_w_q, mem_w_d;
  logic [addr_width_p-1:0]   mem_addr_q, mem_addr_d;
  logic [data_width_p-1:0]   mem_data_q, mem_data_d;
  logic [mask_width_lp-1:0]  mem_mask_q, mem_mask_d;
  logic                      mem_remote_q, mem_remote_d;
  logic                      freeze_q, freeze_d;
  logic                      error_q, error_d;
  logic                      cfg_credit_q, cfg_credit_d;
  logic [StreakW-1:0]        streak_q, streak_d;

  logic is_store, is_cfg;
  logic busy, slot_free, core_ok, core_starved;
  logic pkt_grant, core_grant;

  assign is_store = (pkt.op == OpStore);
  assign is_cfg   = (pkt.op == OpConfig) && (pkt.addr == '0);

  assign busy      = (state_q == StBusy);
  assign slot_free = ~busy | mem_yumi_i;
  assign core_ok   = core_v_i & ~freeze_q;

  // Core wins once the network has held the port for max_streak_p grants in a row.
  assign core_starved = core_ok & (streak_q == MaxStreak);

  assign pkt_grant  = slot_free & pkt_v_i & ~core_starved;
  assign core_grant = slot_free & ~pkt_grant & core_ok;

  always_comb begin
    state_d      = state_q;
    mem_w_d      = mem_w_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    mem_mask_d   = mem_mask_q;
    mem_remote_d = mem_remote_q;
    freeze_d     = freeze_q;
    error_d      = error_q;
    cfg_credit_d = 1'b0;
    streak_d     = streak_q;

    if (slot_free) begin
      state_d      = StIdle;
      mem_remote_d = 1'b0;
      if (pkt_grant) begin
        if (is_store) begin
          state_d      = StBusy;
          mem_w_d      = 1'b1;
          mem_addr_d   = pkt.addr;
          mem_data_d   = pkt.data;
          mem_mask_d   = pkt.op_ex;
          mem_remote_d = 1'b1;
        end else begin
          cfg_credit_d = 1'b1;
          if (is_cfg) begin
            freeze_d = pkt.data[0];
          end else begin
            error_d = 1'b1;
          end
        end
      end else if (core_grant) begin
        state_d      = StBusy;
        mem_w_d      = core_w_i;
        mem_addr_d   = core_addr_i;
        mem_data_d   = core_data_i;
        mem_mask_d   = core_mask_i;
        mem_remote_d = 1'b0;
      end
    end

    if (!core_v_i || core_grant) begin
      streak_d = '0;
    end else if (pkt_grant && is_store && core_ok && (streak_q != MaxStreak)) begin
      streak_d = streak_q + StreakW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= StIdle;
      mem_w_q      <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_mask_q   <= '0;
      mem_remote_q <= 1'b0;
      freeze_q     <= 1'b1;
      error_q      <= 1'b0;
      cfg_credit_q <= 1'b0;
      streak_q     <= '0;
    end else begin
      state_q      <= state_d;
      mem_w_q      <= mem_w_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_mask_q   <= mem_mask_d;
      mem_remote_q <= mem_remote_d;
      freeze_q     <= freeze_d;
      error_q      <= error_d;
      cfg_credit_q <= cfg_credit_d;
      streak_q     <= streak_d;
    end
  end

  assign pkt_yumi_o   = pkt_grant;
  assign core_yumi_o  = core_grant;
  assign mem_v_o      = busy;
  assign mem_w_o      = mem_w_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;
  assign mem_mask_o   = mem_mask_q;
  assign mem_remote_o = mem_remote_q;
  assign freeze_o     = freeze_q;
  assign error_o      = error_q;

  // A config consume leaves the port idle next cycle, so both terms never fire together.
  assign credit_v_o = (mem_yumi_i & mem_remote_q) | cfg_credit_q;

endmodule
